// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload modes driving CP0 HWInt[0]
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3;
  logic [3:0]  ctrl;
  logic [31:0] preset, count;
  logic [1:0]  state;
  logic        irq_flag, en, auto_mode, ack, expire;
  always_comb begin
    en = ctrl[0];
    auto_mode = ctrl[2:1] == 2'b01;
    ack = we && !addr[1];
    expire = state == CNT && en && count <= 32'd1;
  end
  assign dout = addr == 2'd0 ? {28'b0, ctrl} : addr == 2'd1 ? preset : addr == 2'd2 ? count : 32'b0;
  assign irq = ctrl[3] & irq_flag;
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 4'b0;
      preset <= 32'b0;
      count <= 32'b0;
      state <= IDLE;
      irq_flag <= 1'b0;
    end else begin
      if (we && addr == 2'd0) ctrl <= din[3:0];
      else if (state == INT && !auto_mode) ctrl[0] <= 1'b0;
      if (we && addr == 2'd1) preset <= din;
      // an acknowledge in the expiry edge beats the flag set
      irq_flag <= ack ? 1'b0 : expire ? 1'b1 : (state == INT && auto_mode) ? 1'b0 : irq_flag;
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) state <= IDLE;
          else if (count > 32'd1) count <= count - 32'd1;
          else begin
            count <= 32'b0;
            state <= INT;
          end
        end
        INT: state <= IDLE;
      endcase
    end
  end
endmodule
